// File: rtl/accumulator_pkg.sv
// Shared types and helpers for the accumulator family: FSM state encoding
// and the signed saturation limits used by the adder.
package accumulator_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
  } sat_limits_t;

  function automatic sat_limits_t sat_limits(input int width);
    sat_limits_t lim;
    lim.max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    lim.min_v = -(32'sd1 <<< (width - 1));
    return lim;
  endfunction

endpackage

// File: rtl/accumulator_bank_if.sv
// Transaction and result bus of the accumulator bank; the producer side uses
// the master modport, the bank itself uses the slave modport.
interface accumulator_bank_if #(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_ACC_WIDTH  = 12,
  parameter int p_CHANNELS   = 4
) ();
  localparam int p_CH_WIDTH = $clog2(p_CHANNELS);

  logic                    i_CLK_ENABLE;
  logic                    i_VALID;
  logic                    o_READY;
  logic [p_CH_WIDTH-1:0]   i_CHANNEL;
  logic [p_DATA_WIDTH-1:0] i_SUMMAND;
  logic                    i_LOAD;
  logic                    i_DUMP;
  logic                    o_VALID;
  logic [p_CH_WIDTH-1:0]   o_CHANNEL;
  logic [p_ACC_WIDTH-1:0]  o_ACCUMULATION;
  logic                    o_SATURATED;
  logic [p_CHANNELS-1:0]   o_STICKY_OVF;
  logic                    o_DUMP_DONE;

  modport master (
    output i_CLK_ENABLE, i_VALID, i_CHANNEL, i_SUMMAND, i_LOAD, i_DUMP,
    input  o_READY, o_VALID, o_CHANNEL, o_ACCUMULATION, o_SATURATED,
           o_STICKY_OVF, o_DUMP_DONE
  );

  modport slave (
    input  i_CLK_ENABLE, i_VALID, i_CHANNEL, i_SUMMAND, i_LOAD, i_DUMP,
    output o_READY, o_VALID, o_CHANNEL, o_ACCUMULATION, o_SATURATED,
           o_STICKY_OVF, o_DUMP_DONE
  );
endinterface

// File: rtl/accumulator_sat_add.sv
// Combinational signed accumulate step: widen by one bit, add, detect overflow
// from the top two bits, then clamp or wrap.
module accumulator_sat_add
  import accumulator_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_ACC_WIDTH  = 12,
  parameter int p_SATURATE   = 1
) (
  input  logic [p_ACC_WIDTH-1:0]  acc,
  input  logic [p_DATA_WIDTH-1:0] summand,
  output logic [p_ACC_WIDTH-1:0]  sum,
  output logic                    overflow
);
  localparam int          c_EXT = p_ACC_WIDTH + 1;
  localparam sat_limits_t c_LIM = sat_limits(p_ACC_WIDTH);
  localparam logic [p_ACC_WIDTH-1:0] c_MAX = c_LIM.max_v[p_ACC_WIDTH-1:0];
  localparam logic [p_ACC_WIDTH-1:0] c_MIN = c_LIM.min_v[p_ACC_WIDTH-1:0];

  logic signed [p_ACC_WIDTH:0] ext_sum_s;

  // Widened add with overflow detection and clamp/wrap selection
  always_comb begin
    ext_sum_s = c_EXT'($signed(acc)) + c_EXT'($signed(summand));
    overflow  = ext_sum_s[p_ACC_WIDTH] ^ ext_sum_s[p_ACC_WIDTH-1];
    sum       = ext_sum_s[p_ACC_WIDTH-1:0];
    if (overflow && (p_SATURATE != 0)) begin
      sum = ext_sum_s[p_ACC_WIDTH] ? c_MIN : c_MAX;
    end else begin
      sum = ext_sum_s[p_ACC_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/accumulator_bank.sv
// Multi-channel signed accumulator bank with sticky overflow flags and a
// readout-and-clear dump sequencer that streams every channel in order.
module accumulator_bank
  import accumulator_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_ACC_WIDTH  = 12,
  parameter int p_CHANNELS   = 4,
  parameter int p_SATURATE   = 1
) (
  input logic               i_CLK,
  input logic               i_RESET,
  accumulator_bank_if.slave bus
);
  localparam int p_CH_WIDTH = $clog2(p_CHANNELS);

  if (p_ACC_WIDTH < p_DATA_WIDTH) begin : g_bad_width
    $error("accumulator_bank: p_ACC_WIDTH must be >= p_DATA_WIDTH");
  end
  if (p_CHANNELS < 2) begin : g_bad_channels
    $error("accumulator_bank: p_CHANNELS must be >= 2");
  end

  logic [p_ACC_WIDTH-1:0] acc_r [p_CHANNELS];
  logic [p_CHANNELS-1:0]  sticky_r;
  acc_state_e             state_r, state_next_s;
  logic [p_CH_WIDTH-1:0]  cnt_r;
  logic                   valid_r, sat_r, done_r;
  logic [p_CH_WIDTH-1:0]  channel_r;
  logic [p_ACC_WIDTH-1:0] accum_r;

  logic                   accept_s, ch_ok_s, dump_last_s, ovf_s;
  logic [p_ACC_WIDTH-1:0] cur_acc_s, sum_s, load_val_s;

  assign bus.o_READY        = (state_r == ST_IDLE);
  assign bus.o_VALID        = valid_r;
  assign bus.o_CHANNEL      = channel_r;
  assign bus.o_ACCUMULATION = accum_r;
  assign bus.o_SATURATED    = sat_r;
  assign bus.o_STICKY_OVF   = sticky_r;
  assign bus.o_DUMP_DONE    = done_r;

  assign accept_s   = bus.i_VALID && (state_r == ST_IDLE);
  assign ch_ok_s    = (32'(bus.i_CHANNEL) < 32'(p_CHANNELS));
  assign cur_acc_s  = ch_ok_s ? acc_r[bus.i_CHANNEL] : '0;
  assign load_val_s = p_ACC_WIDTH'($signed(bus.i_SUMMAND));

  accumulator_sat_add #(
    .p_DATA_WIDTH(p_DATA_WIDTH),
    .p_ACC_WIDTH (p_ACC_WIDTH),
    .p_SATURATE  (p_SATURATE)
  ) u_sat_add (
    .acc     (cur_acc_s),
    .summand (bus.i_SUMMAND),
    .sum     (sum_s),
    .overflow(ovf_s)
  );

  // Next-state logic for the IDLE/DUMP sequencer
  always_comb begin
    state_next_s = state_r;
    dump_last_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_DUMP) state_next_s = ST_DUMP;
        else            state_next_s = ST_IDLE;
      end
      ST_DUMP: begin
        dump_last_s = (cnt_r == p_CH_WIDTH'(p_CHANNELS - 1));
        if (dump_last_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_DUMP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, channel storage and registered result outputs
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      sticky_r  <= '0;
      valid_r   <= 1'b0;
      channel_r <= '0;
      accum_r   <= '0;
      sat_r     <= 1'b0;
      done_r    <= 1'b0;
      for (int i = 0; i < p_CHANNELS; i++) acc_r[i] <= '0;
    end else if (bus.i_CLK_ENABLE) begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          // Out-of-range channels are consumed silently
          if (accept_s && ch_ok_s) begin
            valid_r   <= 1'b1;
            channel_r <= bus.i_CHANNEL;
            if (bus.i_LOAD) begin
              acc_r[bus.i_CHANNEL]    <= load_val_s;
              accum_r                 <= load_val_s;
              sat_r                   <= 1'b0;
              sticky_r[bus.i_CHANNEL] <= 1'b0;
            end else begin
              acc_r[bus.i_CHANNEL]    <= sum_s;
              accum_r                 <= sum_s;
              sat_r                   <= ovf_s;
              sticky_r[bus.i_CHANNEL] <= sticky_r[bus.i_CHANNEL] | ovf_s;
            end
          end else begin
            valid_r <= 1'b0;
            sat_r   <= 1'b0;
          end
        end
        ST_DUMP: begin
          valid_r         <= 1'b1;
          channel_r       <= cnt_r;
          accum_r         <= acc_r[cnt_r];
          sat_r           <= sticky_r[cnt_r];
          acc_r[cnt_r]    <= '0;
          sticky_r[cnt_r] <= 1'b0;
          done_r          <= dump_last_s;
          cnt_r           <= dump_last_s ? '0 : cnt_r + p_CH_WIDTH'(1);
        end
        default: begin
          valid_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end
endmodule
